// File: rtl/fp_mul_normround.sv
// Floating-point multiply back end: normalizes a raw significand product, rounds to nearest-even
// and packs an IEEE-754 result. Define FP_NORM_SHIFT4_EN to allow 4-bit normalization steps.
module fp_mul_normround #(
    parameter int unsigned SIG_W = 24,
    parameter int unsigned EXP_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            prod,
    input  logic [EXP_W+1:0]       exp_sum,
    input  logic                   sign,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+SIG_W-1:0] result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   inexact
);

    localparam int unsigned PM = 2 * SIG_W - 1;
    localparam int unsigned RW = EXP_W + SIG_W;
    localparam int unsigned EW = EXP_W + 3;
    localparam logic signed [EW-1:0] EMAX = EW'(2 ** EXP_W - 1);

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    state_e               state_q, state_d;
    logic [PM:0]          m_q, m_d;
    logic signed [EW-1:0] e_q, e_d;
    logic                 sign_q, sign_d;
    logic                 out_valid_q, out_valid_d;
    logic [RW-1:0]        result_q, result_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 inexact_q, inexact_d;

    logic [SIG_W-2:0]     frac;
    logic                 guard_bit;
    logic                 sticky;
    logic                 round_up;
    logic [SIG_W-1:0]     frac_sum;
    logic signed [EW-1:0] e_rnd;
    logic                 unused_prod;

    assign unused_prod = ^prod[63:PM+1];

    assign in_ready  = (state_q == StIdle) && !reset;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign inexact   = inexact_q;

    // Round to nearest, ties to even; a carry out of the fraction bumps the exponent.
    assign frac      = m_q[PM-1:SIG_W];
    assign guard_bit = m_q[SIG_W-1];
    assign sticky    = |m_q[SIG_W-2:0];
    assign round_up  = guard_bit & (sticky | frac[0]);
    assign frac_sum  = {1'b0, frac} + {{(SIG_W-1){1'b0}}, round_up};
    assign e_rnd     = e_q + {{(EW-1){1'b0}}, frac_sum[SIG_W-1]};

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        e_d         = e_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inexact_d   = inexact_q;

        case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    m_d         = prod[PM:0];
                    e_d         = {exp_sum[EXP_W+1], exp_sum} + EW'(1);
                    sign_d      = sign;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    inexact_d   = 1'b0;
                    if (prod[PM:0] == '0) begin
                        result_d    = {sign, {(RW-1){1'b0}}};
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        state_d = StNorm;
                    end
                end
            end
            StNorm: begin
                if (m_q[PM]) begin
                    state_d = StRound;
`ifdef FP_NORM_SHIFT4_EN
                end else if (m_q[PM -: 4] == 4'b0000) begin
                    m_d = m_q << 4;
                    e_d = e_q - EW'(4);
`endif
                end else begin
                    m_d = m_q << 1;
                    e_d = e_q - EW'(1);
                end
            end
            StRound: begin
                out_valid_d = 1'b1;
                state_d     = StDone;
                if (e_rnd >= EMAX) begin
                    result_d    = {sign_q, {EXP_W{1'b1}}, {(SIG_W-1){1'b0}}};
                    overflow_d  = 1'b1;
                    underflow_d = 1'b0;
                    inexact_d   = 1'b1;
                end else if (e_rnd[EW-1] || (e_rnd == '0)) begin
                    // No denormals: anything at or below exponent zero flushes.
                    result_d    = {sign_q, {(RW-1){1'b0}}};
                    overflow_d  = 1'b0;
                    underflow_d = 1'b1;
                    inexact_d   = 1'b1;
                end else begin
                    result_d    = {sign_q, e_rnd[EXP_W-1:0], frac_sum[SIG_W-2:0]};
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    inexact_d   = guard_bit | sticky;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            m_q         <= '0;
            e_q         <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            e_q         <= e_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            inexact_q   <= inexact_d;
        end
    end

endmodule
